// File: rtl/load_store_unit.sv
// MEM-stage load/store unit for the RV64 pipeline: one outstanding data-memory access,
// load alignment/extension, store strobes, and the MEM/WB register feeding write-back.
module load_store_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        mem_read_i,
   input  logic        mem_write_i,
   input  logic [2:0]  funct3_i,
   input  logic [63:0] addr_i,
   input  logic [63:0] wdata_i,
   input  logic [4:0]  rd_i,
   input  logic        reg_write_i,
   output logic        stall_o,
   output logic        dmem_req_o,
   output logic        dmem_we_o,
   output logic [63:0] dmem_addr_o,
   output logic [63:0] dmem_wdata_o,
   output logic [7:0]  dmem_wstrb_o,
   input  logic [63:0] dmem_rdata_i,
   input  logic        dmem_ready_i,
   output logic        wb_valid_o,
   output logic [4:0]  wb_rd_o,
   output logic        wb_reg_write_o,
   output logic [63:0] wb_data_o,
   output logic        fault_o
);

   typedef enum logic {
      IDLE = 1'b0,
      BUSY = 1'b1
   } state_t;

   state_t      state_q, state_d;
   logic        stall_c;

   logic        is_store_q, is_store_d;
   logic [2:0]  funct3_q, funct3_d;
   logic [2:0]  off_q, off_d;
   logic [4:0]  rd_q, rd_d;
   logic        reg_write_q, reg_write_d;

   logic        dmem_req_q, dmem_req_d;
   logic        dmem_we_q, dmem_we_d;
   logic [63:0] dmem_addr_q, dmem_addr_d;
   logic [63:0] dmem_wdata_q, dmem_wdata_d;
   logic [7:0]  dmem_wstrb_q, dmem_wstrb_d;

   logic        wb_valid_q, wb_valid_d;
   logic [4:0]  wb_rd_q, wb_rd_d;
   logic        wb_reg_write_q, wb_reg_write_d;
   logic [63:0] wb_data_q, wb_data_d;
   logic        fault_q, fault_d;

   logic        mem_op;
   logic        illegal_op;
   logic        access_fault;

   function automatic logic misaligned(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'b00:   misaligned = 1'b0;
         2'b01:   misaligned = off[0];
         2'b10:   misaligned = (off[1:0] != 2'b00);
         default: misaligned = (off != 3'b000);
      endcase
   endfunction

   function automatic logic [7:0] store_strobe(input logic [1:0] size, input logic [2:0] off);
      case (size)
         2'b00:   store_strobe = 8'h01 << off;
         2'b01:   store_strobe = 8'h03 << off;
         2'b10:   store_strobe = 8'h0F << off;
         default: store_strobe = 8'hFF;
      endcase
   endfunction

   // Replicating the datum into every lane lets the strobes alone pick the bytes.
   function automatic logic [63:0] store_lanes(input logic [1:0] size, input logic [63:0] d);
      case (size)
         2'b00:   store_lanes = {8{d[7:0]}};
         2'b01:   store_lanes = {4{d[15:0]}};
         2'b10:   store_lanes = {2{d[31:0]}};
         default: store_lanes = d;
      endcase
   endfunction

   function automatic logic [63:0] load_extract(input logic [2:0] f3, input logic [2:0] off,
                                                input logic [63:0] rdata);
      logic [63:0] sh;
      sh = rdata >> {off, 3'b000};
      case (f3)
         3'b000:  load_extract = {{56{sh[7]}}, sh[7:0]};
         3'b001:  load_extract = {{48{sh[15]}}, sh[15:0]};
         3'b010:  load_extract = {{32{sh[31]}}, sh[31:0]};
         3'b100:  load_extract = {56'd0, sh[7:0]};
         3'b101:  load_extract = {48'd0, sh[15:0]};
         3'b110:  load_extract = {32'd0, sh[31:0]};
         default: load_extract = sh;
      endcase
   endfunction

   assign mem_op       = mem_read_i | mem_write_i;
   assign illegal_op   = (mem_read_i & mem_write_i)
                       | (mem_read_i & (funct3_i == 3'b111))
                       | (mem_write_i & funct3_i[2]);
   assign access_fault = mem_op & (illegal_op | misaligned(funct3_i[1:0], addr_i[2:0]));

   always_comb begin
      state_d        = state_q;
      stall_c        = 1'b0;
      is_store_d     = is_store_q;
      funct3_d       = funct3_q;
      off_d          = off_q;
      rd_d           = rd_q;
      reg_write_d    = reg_write_q;
      dmem_req_d     = dmem_req_q;
      dmem_we_d      = dmem_we_q;
      dmem_addr_d    = dmem_addr_q;
      dmem_wdata_d   = dmem_wdata_q;
      dmem_wstrb_d   = dmem_wstrb_q;
      wb_valid_d     = 1'b0;
      wb_rd_d        = wb_rd_q;
      wb_reg_write_d = 1'b0;
      wb_data_d      = wb_data_q;
      fault_d        = 1'b0;

      case (state_q)
         IDLE: begin
            if (mem_op && !access_fault) begin
               stall_c      = 1'b1;
               state_d      = BUSY;
               is_store_d   = mem_write_i;
               funct3_d     = funct3_i;
               off_d        = addr_i[2:0];
               rd_d         = rd_i;
               reg_write_d  = reg_write_i;
               dmem_req_d   = 1'b1;
               dmem_we_d    = mem_write_i;
               dmem_addr_d  = {addr_i[63:3], 3'b000};
               dmem_wdata_d = mem_write_i ? store_lanes(funct3_i[1:0], wdata_i) : 64'd0;
               dmem_wstrb_d = mem_write_i ? store_strobe(funct3_i[1:0], addr_i[2:0]) : 8'h00;
            end else if (mem_op) begin
               wb_valid_d = 1'b1;
               wb_rd_d    = rd_i;
               wb_data_d  = addr_i;
               fault_d    = 1'b1;
            end else begin
               wb_valid_d     = 1'b1;
               wb_rd_d        = rd_i;
               wb_reg_write_d = reg_write_i && (rd_i != 5'd0);
               wb_data_d      = addr_i;
            end
         end
         BUSY: begin
            if (dmem_ready_i) begin
               state_d        = IDLE;
               dmem_req_d     = 1'b0;
               wb_valid_d     = 1'b1;
               wb_rd_d        = rd_q;
               wb_reg_write_d = !is_store_q && reg_write_q && (rd_q != 5'd0);
               wb_data_d      = is_store_q ? 64'd0 : load_extract(funct3_q, off_q, dmem_rdata_i);
            end else begin
               stall_c = 1'b1;
            end
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q        <= IDLE;
         is_store_q     <= 1'b0;
         funct3_q       <= 3'd0;
         off_q          <= 3'd0;
         rd_q           <= 5'd0;
         reg_write_q    <= 1'b0;
         dmem_req_q     <= 1'b0;
         dmem_we_q      <= 1'b0;
         dmem_addr_q    <= 64'd0;
         dmem_wdata_q   <= 64'd0;
         dmem_wstrb_q   <= 8'h00;
         wb_valid_q     <= 1'b0;
         wb_rd_q        <= 5'd0;
         wb_reg_write_q <= 1'b0;
         wb_data_q      <= 64'd0;
         fault_q        <= 1'b0;
      end else begin
         state_q        <= state_d;
         is_store_q     <= is_store_d;
         funct3_q       <= funct3_d;
         off_q          <= off_d;
         rd_q           <= rd_d;
         reg_write_q    <= reg_write_d;
         dmem_req_q     <= dmem_req_d;
         dmem_we_q      <= dmem_we_d;
         dmem_addr_q    <= dmem_addr_d;
         dmem_wdata_q   <= dmem_wdata_d;
         dmem_wstrb_q   <= dmem_wstrb_d;
         wb_valid_q     <= wb_valid_d;
         wb_rd_q        <= wb_rd_d;
         wb_reg_write_q <= wb_reg_write_d;
         wb_data_q      <= wb_data_d;
         fault_q        <= fault_d;
      end
   end

   // The stall must read low while reset is held, even if EX/MEM presents a memory op.
   assign stall_o        = stall_c & ~rst;
   assign dmem_req_o     = dmem_req_q;
   assign dmem_we_o      = dmem_we_q;
   assign dmem_addr_o    = dmem_addr_q;
   assign dmem_wdata_o   = dmem_wdata_q;
   assign dmem_wstrb_o   = dmem_wstrb_q;
   assign wb_valid_o     = wb_valid_q;
   assign wb_rd_o        = wb_rd_q;
   assign wb_reg_write_o = wb_reg_write_q;
   assign wb_data_o      = wb_data_q;
   assign fault_o        = fault_q;

endmodule

// File: tb/tb_load_store_unit.sv
// Bench for load_store_unit: directed cases plus random ops against a byte-level memory model.
module tb_load_store_unit;

   logic        clk;
   logic        rst;
   logic        mem_read_i;
   logic        mem_write_i;
   logic [2:0]  funct3_i;
   logic [63:0] addr_i;
   logic [63:0] wdata_i;
   logic [4:0]  rd_i;
   logic        reg_write_i;
   logic        stall_o;
   logic        dmem_req_o;
   logic        dmem_we_o;
   logic [63:0] dmem_addr_o;
   logic [63:0] dmem_wdata_o;
   logic [7:0]  dmem_wstrb_o;
   logic [63:0] dmem_rdata_i;
   logic        dmem_ready_i;
   logic        wb_valid_o;
   logic [4:0]  wb_rd_o;
   logic        wb_reg_write_o;
   logic [63:0] wb_data_o;
   logic        fault_o;

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   logic [7:0]  ref_mem [0:255];
   logic [63:0] dmem_words [0:31];
   logic [63:0] last_wdata;
   logic [7:0]  last_wstrb;

   load_store_unit dut (
      .clk            (clk),
      .rst            (rst),
      .mem_read_i     (mem_read_i),
      .mem_write_i    (mem_write_i),
      .funct3_i       (funct3_i),
      .addr_i         (addr_i),
      .wdata_i        (wdata_i),
      .rd_i           (rd_i),
      .reg_write_i    (reg_write_i),
      .stall_o        (stall_o),
      .dmem_req_o     (dmem_req_o),
      .dmem_we_o      (dmem_we_o),
      .dmem_addr_o    (dmem_addr_o),
      .dmem_wdata_o   (dmem_wdata_o),
      .dmem_wstrb_o   (dmem_wstrb_o),
      .dmem_rdata_i   (dmem_rdata_i),
      .dmem_ready_i   (dmem_ready_i),
      .wb_valid_o     (wb_valid_o),
      .wb_rd_o        (wb_rd_o),
      .wb_reg_write_o (wb_reg_write_o),
      .wb_data_o      (wb_data_o),
      .fault_o        (fault_o)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
      end else begin
         n_pass++;
      end
   endtask

   task automatic poke_byte(input int a, input logic [7:0] v);
      ref_mem[a] = v;
      dmem_words[a / 8][8 * (a % 8) +: 8] = v;
   endtask

   function automatic logic [63:0] model_load(input logic [2:0] f3, input int a);
      int n;
      logic [63:0] v;
      n = 1 << f3[1:0];
      v = 64'd0;
      for (int i = 0; i < n; i++) v = v | (64'(ref_mem[a + i]) << (8 * i));
      if (!f3[2] && n < 8 && v[8 * n - 1]) v = v | ~((64'd1 << (8 * n)) - 64'd1);
      return v;
   endfunction

   task automatic scramble_inputs();
      mem_read_i  = 1'($urandom);
      mem_write_i = 1'($urandom);
      funct3_i    = 3'($urandom);
      addr_i      = {$urandom, $urandom};
      wdata_i     = {$urandom, $urandom};
      rd_i        = 5'($urandom);
      reg_write_i = 1'($urandom);
   endtask

   // Called and returns one time unit after a rising edge.
   task automatic run_op(input logic rd_en, input logic wr_en, input logic [2:0] f3,
                         input logic [63:0] addr, input logic [63:0] wdata, input logic [4:0] rd,
                         input logic rw, input int k, input logic keep_ready);
      int       n;
      int       off;
      int       a;
      logic     is_mem;
      logic     flt;
      logic     exp_rw;
      logic [7:0]  exp_strb;
      logic [63:0] exp_data;
      n      = 1 << f3[1:0];
      off    = int'(addr[2:0]);
      a      = int'(addr[7:0]);
      is_mem = rd_en | wr_en;
      flt    = is_mem && ((rd_en && wr_en) || (rd_en && f3 == 3'b111) || (wr_en && f3 > 3'b011)
                          || (int'(addr[7:0]) % n != 0));
      exp_rw = rw && (rd != 5'd0) && !flt && !wr_en;

      mem_read_i   = rd_en;
      mem_write_i  = wr_en;
      funct3_i     = f3;
      addr_i       = addr;
      wdata_i      = wdata;
      rd_i         = rd;
      reg_write_i  = rw;
      dmem_ready_i = 1'($urandom);
      dmem_rdata_i = {$urandom, $urandom};
      #1;

      if (!is_mem || flt) begin
         check_eq("stall_idle", 64'(stall_o), 64'(0));
         @(posedge clk); #1;
         check_eq("req_none", 64'(dmem_req_o), 64'(0));
         check_eq("wb_valid", 64'(wb_valid_o), 64'(1));
         check_eq("wb_rd", 64'(wb_rd_o), 64'(rd));
         check_eq("wb_rw", 64'(wb_reg_write_o), 64'(exp_rw));
         check_eq("wb_data", wb_data_o, addr);
         check_eq("fault", 64'(fault_o), 64'(flt));
         dmem_ready_i = keep_ready;
         return;
      end

      check_eq("stall_issue", 64'(stall_o), 64'(1));
      @(posedge clk); #1;
      exp_strb = 8'((((1 << n) - 1) << off) & 255);
      check_eq("req_up", 64'(dmem_req_o), 64'(1));
      check_eq("req_we", 64'(dmem_we_o), 64'(wr_en));
      check_eq("req_addr", dmem_addr_o, {addr[63:3], 3'b000});
      check_eq("bubble_valid", 64'(wb_valid_o), 64'(0));
      if (wr_en) begin
         check_eq("wstrb", 64'(dmem_wstrb_o), 64'(exp_strb));
         for (int b = 0; b < 8; b++)
            if (exp_strb[b])
               check_eq("wlane", 64'(dmem_wdata_o[8 * b +: 8]), 64'(wdata[8 * (b - off) +: 8]));
         last_wdata = dmem_wdata_o;
         last_wstrb = dmem_wstrb_o;
      end
      scramble_inputs();

      for (int c = 1; c < k; c++) begin
         dmem_ready_i = 1'b0;
         dmem_rdata_i = {$urandom, $urandom};
         #1;
         check_eq("stall_busy", 64'(stall_o), 64'(1));
         check_eq("req_hold", 64'(dmem_req_o), 64'(1));
         check_eq("addr_hold", dmem_addr_o, {addr[63:3], 3'b000});
         @(posedge clk); #1;
      end

      dmem_ready_i = 1'b1;
      dmem_rdata_i = dmem_words[a / 8];
      exp_data     = model_load(f3, a);
      #1;
      check_eq("stall_done", 64'(stall_o), 64'(0));
      if (wr_en) begin
         for (int b = 0; b < 8; b++)
            if (dmem_wstrb_o[b]) dmem_words[a / 8][8 * b +: 8] = dmem_wdata_o[8 * b +: 8];
         for (int i = 0; i < n; i++) ref_mem[a + i] = wdata[8 * i +: 8];
      end
      @(posedge clk); #1;
      check_eq("req_drop", 64'(dmem_req_o), 64'(0));
      check_eq("wb_valid_mem", 64'(wb_valid_o), 64'(1));
      check_eq("wb_rd_mem", 64'(wb_rd_o), 64'(rd));
      check_eq("wb_rw_mem", 64'(wb_reg_write_o), 64'(exp_rw));
      check_eq("fault_mem", 64'(fault_o), 64'(0));
      if (!wr_en) check_eq("load_data", wb_data_o, exp_data);
      dmem_ready_i = keep_ready;
   endtask

   initial begin
      rst = 1'b1;
      mem_read_i = 1'b0; mem_write_i = 1'b0; funct3_i = 3'd0; addr_i = 64'd0;
      wdata_i = 64'd0; rd_i = 5'd0; reg_write_i = 1'b0;
      dmem_rdata_i = 64'd0; dmem_ready_i = 1'b0;
      last_wdata = 64'd0; last_wstrb = 8'h00;
      for (int i = 0; i < 256; i++) poke_byte(i, 8'($urandom));

      repeat (2) @(posedge clk);
      #1;
      check_eq("rst_stall", 64'(stall_o), 64'(0));
      check_eq("rst_req", 64'(dmem_req_o), 64'(0));
      check_eq("rst_we", 64'(dmem_we_o), 64'(0));
      check_eq("rst_addr", dmem_addr_o, 64'd0);
      check_eq("rst_wdata", dmem_wdata_o, 64'd0);
      check_eq("rst_wstrb", 64'(dmem_wstrb_o), 64'(0));
      check_eq("rst_wb_valid", 64'(wb_valid_o), 64'(0));
      check_eq("rst_wb_rd", 64'(wb_rd_o), 64'(0));
      check_eq("rst_wb_rw", 64'(wb_reg_write_o), 64'(0));
      check_eq("rst_wb_data", wb_data_o, 64'd0);
      check_eq("rst_fault", 64'(fault_o), 64'(0));
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;

      run_op(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1, 1, 1'b0);
      run_op(1'b0, 1'b0, 3'd0, 64'h55, 64'd0, 5'd0, 1'b1, 1, 1'b0);

      poke_byte(8'h13, 8'h80);
      run_op(1'b1, 1'b0, 3'b000, 64'h13, 64'd0, 5'd10, 1'b1, 3, 1'b0);
      check_eq("lb_value", wb_data_o, 64'hFFFF_FFFF_FFFF_FF80);
      run_op(1'b1, 1'b0, 3'b100, 64'h13, 64'd0, 5'd10, 1'b1, 3, 1'b0);
      check_eq("lbu_value", wb_data_o, 64'h80);

      run_op(1'b0, 1'b1, 3'b001, 64'h0A, 64'hBEEF, 5'd3, 1'b1, 1, 1'b0);
      check_eq("sh_wstrb", 64'(last_wstrb), 64'h0C);
      check_eq("sh_wdata", last_wdata, 64'hBEEF_BEEF_BEEF_BEEF);
      check_eq("sh_no_wb", 64'(wb_reg_write_o), 64'(0));

      run_op(1'b1, 1'b0, 3'b010, 64'h06, 64'd0, 5'd4, 1'b1, 1, 1'b0);
      check_eq("lw_mis_fault", 64'(fault_o), 64'(1));
      check_eq("lw_mis_data", wb_data_o, 64'h06);

      run_op(1'b1, 1'b0, 3'b011, 64'h0, 64'd0, 5'd7, 1'b1, 1, 1'b1);
      run_op(1'b0, 1'b1, 3'b011, 64'h8, 64'h0123_4567_89AB_CDEF, 5'd8, 1'b0, 1, 1'b1);
      dmem_ready_i = 1'b0;

      run_op(1'b0, 1'b0, 3'd0, 64'hDEAD, 64'd0, 5'd9, 1'b1, 1, 1'b0);
      mem_read_i = 1'b1; mem_write_i = 1'b0; funct3_i = 3'b011; addr_i = 64'h40; rd_i = 5'd11;
      reg_write_i = 1'b1; dmem_ready_i = 1'b0;
      @(posedge clk); #1;
      check_eq("pre_rst_req", 64'(dmem_req_o), 64'(1));
      #2 rst = 1'b1;
      #1;
      check_eq("mid_rst_req", 64'(dmem_req_o), 64'(0));
      check_eq("mid_rst_stall", 64'(stall_o), 64'(0));
      check_eq("mid_rst_wb_valid", 64'(wb_valid_o), 64'(0));
      check_eq("mid_rst_wb_rd", 64'(wb_rd_o), 64'(0));
      check_eq("mid_rst_wb_rw", 64'(wb_reg_write_o), 64'(0));
      check_eq("mid_rst_wb_data", wb_data_o, 64'd0);
      check_eq("mid_rst_fault", 64'(fault_o), 64'(0));
      mem_read_i = 1'b0;
      @(negedge clk) rst = 1'b0;
      @(posedge clk); #1;
      run_op(1'b0, 1'b0, 3'd0, 64'h1234, 64'd0, 5'd5, 1'b1, 1, 1'b0);

      for (int t = 0; t < 400; t++) begin
         int          kind;
         logic [2:0]  f3;
         logic [63:0] a;
         kind = $urandom_range(0, 9);
         f3   = 3'($urandom_range(0, 7));
         if (kind <= 2) begin
            a = {$urandom, $urandom};
         end else begin
            a = 64'($urandom_range(0, 255));
            if ($urandom_range(0, 3) != 0) a = a & ~64'((1 << f3[1:0]) - 1);
         end
         run_op(kind >= 3 && kind != 6 && kind != 7 && kind != 8,
                kind >= 6,
                f3, a, {$urandom, $urandom}, 5'($urandom), 1'($urandom),
                $urandom_range(1, 4), 1'($urandom));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/load_store_unit.md
# load_store_unit

MEM-stage load/store unit for the 64-bit RISC-V pipeline, placed between the EX/MEM register and the write-back stage. It takes the ALU result as the address, drives a data memory over a req/ready handshake, aligns and extends load data, and generates byte strobes for stores. It stalls the upstream pipeline while a memory access is outstanding and contains the MEM/WB pipeline register, so its outputs feed write-back directly.

## Interface
- Parameters: none (XLEN fixed at 64).
- clk  in  1  clock; all state updates on posedge.
- rst  in  1  reset, asynchronous, active-high.
- mem_read_i  in  1  load request from EX/MEM.
- mem_write_i  in  1  store request from EX/MEM.
- funct3_i  in  3  access size/sign (RV64I load/store encoding).
- addr_i  in  64  ALU result; the byte address for memory ops, the result for non-memory ops.
- wdata_i  in  64  store data (rs2), LSB-aligned.
- rd_i  in  5  destination register.
- reg_write_i  in  1  instruction writes rd.
- stall_o  out  1  hold PC, IF/ID, ID/EX and EX/MEM this cycle (combinational).
- dmem_req_o  out  1  memory request (registered).
- dmem_we_o  out  1  1 = store.
- dmem_addr_o  out  64  doubleword address, bits [2:0] = 0.
- dmem_wdata_o  out  64  store data replicated into lanes.
- dmem_wstrb_o  out  8  byte-lane write enables.
- dmem_rdata_i  in  64  read doubleword, valid when dmem_ready_i = 1.
- dmem_ready_i  in  1  access complete this cycle.
- wb_valid_o  out  1  MEM/WB register holds a real instruction.
- wb_rd_o  out  5  destination register.
- wb_reg_write_o  out  1  write-back enable.
- wb_data_o  out  64  load result or passed-through ALU result.
- fault_o  out  1  misaligned access or illegal funct3, carried with the instruction.

## Operation
- FSM states: IDLE and BUSY.
- IDLE, no memory op: MEM/WB loads {valid = 1, rd_i, reg_write_i, data = addr_i, fault = 0} each cycle.
- IDLE with a legal, aligned op: stall_o = 1 and the state moves to BUSY. The unit latches the op, funct3, byte offset, rd, reg_write and strobes/data. dmem_req_o goes to 1 and MEM/WB loads a bubble (valid = 0, reg_write = 0).
- BUSY, dmem_ready_i = 0: stall_o = 1, all dmem_* outputs held stable, MEM/WB loads a bubble.
- BUSY, dmem_ready_i = 1: stall_o = 0 and dmem_req_o drops at the next edge. At that edge the state returns to IDLE and MEM/WB loads the instruction.
  - For a load, data is the extracted value and reg_write is the latched value.
  - For a store, reg_write = 0.
- Alignment rules:
  - Halfword: addr[0] = 0.
  - Word: addr[1:0] = 0.
  - Doubleword: addr[2:0] = 0.
- Faults:
  - A misaligned access, load funct3 = 111, store funct3 > 011, or mem_read_i and mem_write_i both set is a fault.
  - A fault issues no memory request and no stall.
  - MEM/WB loads {valid = 1, reg_write = 0, fault = 1}, with data = addr_i (the faulting address).
- Store strobes, where o = addr[2:0]:
  - SB: wstrb = 0x01 << o; the data byte is replicated in all 8 lanes.
  - SH: wstrb = 0x03 << o; the halfword is replicated 4 times.
  - SW: wstrb = 0x0F << o; the word is replicated twice.
  - SD: wstrb = 0xFF.
- Load extract: shift dmem_rdata_i right by 8*o, then take the result by funct3:
  - LB/LH/LW: sign-extend from bit 7/15/31.
  - LBU/LHU/LWU: zero-extend.
  - LD: the full doubleword.
- rd = 0: wb_reg_write_o is forced to 0.

## Timing
- Reset values: state = IDLE, stall_o = 0, all dmem_* outputs = 0, all wb_* outputs = 0, fault_o = 0.
- Non-memory op and faulting op: 1 cycle (present at edge N, visible on wb_* after edge N+1).
- Memory op: present in cycle N, dmem_req_o high from edge N+1, ready in cycle N+k (k ≥ 1), wb_* valid after edge N+k+1. Minimum latency is 2 cycles; the stall lasts k cycles.
- Requests are issued back-to-back: the op behind a completed access is in EX/MEM in cycle N+k+1 and may raise dmem_req_o at edge N+k+2. There is no pipelining of requests and at most 1 outstanding access.
- dmem_ready_i is ignored in IDLE.
- Input changes while BUSY are ignored, because the latched copy is used.
- Reset asserted mid-access: state = IDLE and dmem_req_o = 0 immediately (asynchronous). The abandoned access is not completed, and the memory must discard it.

## Test plan
- Non-memory op, addr_i = 0x1234, rd = 5, reg_write = 1 → next cycle wb_valid = 1, wb_rd = 5, wb_data = 0x1234, stall_o never high.
- LB at addr 0x13, memory returns 0x80 in byte 3, ready after 3 BUSY cycles:
  - stall_o is high for 3 cycles.
  - dmem_addr_o = 0x10.
  - wb_data = 0xFFFF_FFFF_FFFF_FF80; repeating as LBU gives 0x80.
- SH wdata = 0xBEEF at addr 0x0A, ready immediately → dmem_we = 1, wstrb = 0x0C, dmem_wdata_o = 0xBEEF_BEEF_BEEF_BEEF, wb_reg_write = 0, stall 1 cycle.
- LW at addr 0x06 → no dmem_req_o, stall_o = 0, next cycle fault_o = 1, wb_reg_write = 0, wb_data = 0x06.
- Back-to-back LD 0x0 then SD 0x8 with ready held at 1:
  - Two request pulses separated by one idle cycle.
  - LD result appears in MEM/WB before the SD bubble.
- Assert rst during BUSY → dmem_req_o, stall_o and all wb_* outputs are 0 within the same cycle. After release, a non-memory op passes through normally.
